// File: rtl/block_checker_ext.sv
// Streaming begin/end keyword-nesting checker: tracks word-level nesting depth with
// speculative keyword counting, a confirmed high-water mark and sticky errors.
module block_checker_ext #(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255,
  parameter bit CASE_INS  = 1'b1,
  parameter bit WS_SEP    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic [DEPTH_W-1:0] depth_hwm,
  output logic               err_underflow,
  output logic               err_overflow
);

  typedef enum logic [3:0] {
    SEP, B1, B2, B3, B4, BDONE, E1, E2, EDONE, EUF, BOF, SKIP, DEAD
  } state_t;

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);

  state_t             state_reg, state_next;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic [DEPTH_W-1:0] hwm_reg, hwm_next;
  logic               uf_reg, uf_next;
  logic               of_reg, of_next;

  logic is_sep;
  logic m_b, m_e, m_g, m_i, m_n, m_d;

  // Uppercase is accepted only when the case-insensitive option is enabled.
  function automatic logic letter(input logic [7:0] c, input logic [7:0] lower);
    return (c == lower) || (CASE_INS && (c == (lower - 8'h20)));
  endfunction

  assign is_sep = (in == 8'h20) ||
                  (WS_SEP && ((in == 8'h09) || (in == 8'h0A) || (in == 8'h0D)));
  assign m_b = letter(in, 8'h62);
  assign m_e = letter(in, 8'h65);
  assign m_g = letter(in, 8'h67);
  assign m_i = letter(in, 8'h69);
  assign m_n = letter(in, 8'h6E);
  assign m_d = letter(in, 8'h64);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEP;
      depth_reg <= '0;
      hwm_reg   <= '0;
      uf_reg    <= 1'b0;
      of_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      depth_reg <= depth_next;
      hwm_reg   <= hwm_next;
      uf_reg    <= uf_next;
      of_reg    <= of_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    depth_next = depth_reg;
    hwm_next   = hwm_reg;
    uf_next    = uf_reg;
    of_next    = of_reg;
    if (in_valid && (state_reg != DEAD)) begin
      if (is_sep) begin
        state_next = SEP;
        case (state_reg)
          BDONE: hwm_next = (depth_reg > hwm_reg) ? depth_reg : hwm_reg;
          EUF: begin
            uf_next    = 1'b1;
            state_next = DEAD;
          end
          BOF: begin
            of_next    = 1'b1;
            state_next = DEAD;
          end
          default: ;
        endcase
      end else begin
        state_next = SKIP;
        case (state_reg)
          SEP: begin
            if (m_b)      state_next = B1;
            else if (m_e) state_next = E1;
          end
          B1: if (m_e) state_next = B2;
          B2: if (m_g) state_next = B3;
          B3: if (m_i) state_next = B4;
          E1: if (m_n) state_next = E2;
          B4: begin
            if (m_n) begin
              if (depth_reg < MAX_D) begin
                depth_next = depth_reg + ONE;
                state_next = BDONE;
              end else begin
                state_next = BOF;
              end
            end
          end
          E2: begin
            if (m_d) begin
              if (depth_reg != '0) begin
                depth_next = depth_reg - ONE;
                state_next = EDONE;
              end else begin
                state_next = EUF;
              end
            end
          end
          // A keyword that keeps growing was not a keyword: undo the speculation.
          BDONE: depth_next = depth_reg - ONE;
          EDONE: depth_next = depth_reg + ONE;
          default: ;
        endcase
      end
    end
  end

  assign depth         = depth_reg;
  assign depth_hwm     = hwm_reg;
  assign err_underflow = uf_reg;
  assign err_overflow  = of_reg;
  assign result        = (depth_reg == '0) && (state_reg != EUF) && (state_reg != BOF) &&
                         !uf_reg && !of_reg;

endmodule

// File: tb/tb_block_checker_ext.sv
// Four differently configured checkers share one character stream; a word-level
// model per configuration predicts every output after every clock edge.
module tb_block_checker_ext;

  localparam int NC = 4;
  localparam int P_MAX [NC] = '{255, 255, 2, 3};
  localparam bit P_CI  [NC] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit P_WS  [NC] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in = 8'h00;
  logic in_valid = 1'b0;
  logic [NC-1:0] d_res, d_eu, d_eo;
  logic [NC-1:0][7:0] d_dep, d_hwm;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NC; gi++) begin : g_dut
    block_checker_ext #(
      .DEPTH_W(8), .MAX_DEPTH(P_MAX[gi]), .CASE_INS(P_CI[gi]), .WS_SEP(P_WS[gi])
    ) dut (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .result(d_res[gi]), .depth(d_dep[gi]), .depth_hwm(d_hwm[gi]),
      .err_underflow(d_eu[gi]), .err_overflow(d_eo[gi])
    );
  end

  // Word-level model: confirmed depth plus the word currently being typed.
  int m_conf [NC];
  int m_hwm [NC];
  bit m_eu [NC];
  bit m_eo [NC];
  bit m_dead [NC];
  logic [7:0] m_word [NC][6];
  int m_len [NC];

  function automatic bit m_sep(int k, logic [7:0] c);
    return (c == 8'h20) || (P_WS[k] && (c == 8'h09 || c == 8'h0A || c == 8'h0D));
  endfunction

  function automatic logic [7:0] lc(int k, logic [7:0] c);
    if (P_CI[k] && c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
    return c;
  endfunction

  function automatic bit word_is(int k, string kw);
    logic [7:0] kc;
    if (m_len[k] != kw.len()) return 1'b0;
    for (int i = 0; i < kw.len(); i++) begin
      kc = kw[i];
      if (lc(k, m_word[k][i]) != kc) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int exp_depth(int k);
    int d = m_conf[k];
    if (word_is(k, "begin") && m_conf[k] < P_MAX[k]) d++;
    if (word_is(k, "end") && m_conf[k] > 0) d--;
    return d;
  endfunction

  function automatic bit exp_result(int k);
    if (word_is(k, "begin") && m_conf[k] == P_MAX[k]) return 1'b0;
    if (word_is(k, "end") && m_conf[k] == 0) return 1'b0;
    return (exp_depth(k) == 0) && !m_eu[k] && !m_eo[k];
  endfunction

  function automatic void model_reset(int k);
    m_conf[k] = 0; m_hwm[k] = 0; m_eu[k] = 0; m_eo[k] = 0; m_dead[k] = 0; m_len[k] = 0;
  endfunction

  function automatic void model_char(int k, logic [7:0] c);
    if (m_dead[k]) return;
    if (m_sep(k, c)) begin
      if (word_is(k, "begin")) begin
        if (m_conf[k] < P_MAX[k]) begin
          m_conf[k]++;
          if (m_conf[k] > m_hwm[k]) m_hwm[k] = m_conf[k];
        end else begin
          m_eo[k] = 1; m_dead[k] = 1;
        end
      end else if (word_is(k, "end")) begin
        if (m_conf[k] > 0) m_conf[k]--;
        else begin
          m_eu[k] = 1; m_dead[k] = 1;
        end
      end
      m_len[k] = 0;
    end else if (m_len[k] < 6) begin
      m_word[k][m_len[k]] = c;
      m_len[k]++;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NC; k++) begin
        n_tests++;
        if (int'(d_dep[k]) != exp_depth(k) || d_res[k] != exp_result(k) ||
            int'(d_hwm[k]) != m_hwm[k] || d_eu[k] != m_eu[k] || d_eo[k] != m_eo[k]) begin
          n_fail++;
          $display("FAIL cycle_cfg%0d t=%0t: got dep=%0d res=%0b hwm=%0d uf=%0b of=%0b, want dep=%0d res=%0b hwm=%0d uf=%0b of=%0b",
                   k, $time, d_dep[k], d_res[k], d_hwm[k], d_eu[k], d_eo[k],
                   exp_depth(k), exp_result(k), m_hwm[k], m_eu[k], m_eo[k]);
        end
      end
    end
  end

  task automatic step(input logic [7:0] c, input logic v);
    @(negedge clk);
    #1;
    in = c;
    in_valid = v;
    @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) begin
      if (reset) model_reset(k);
      else if (v) model_char(k, c);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(8'h62, 1'b1);
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  string words [10] = '{"begin", "end", "BEGIN", "End", "beginx", "be", "xend", "begin", "begin", "eNd"};
  string seps [5] = '{" ", "\t", "\n", "\r", "  "};

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset_depth", int'(d_dep[0]), 0);
    chk("reset_result", int'(d_res[0]), 1);

    $display("[TB] directed: begin end");
    send("begi"); step("n", 1'b1);
    chk("t1_n_depth", int'(d_dep[0]), 1);
    chk("t1_n_result", int'(d_res[0]), 0);
    send(" en"); step("d", 1'b1);
    chk("t1_d_depth", int'(d_dep[0]), 0);
    chk("t1_d_result", int'(d_res[0]), 1);
    chk("t1_d_hwm", int'(d_hwm[0]), 1);

    $display("[TB] directed: beginx");
    do_reset();
    send("begi"); step("n", 1'b1);
    chk("t2_n_depth", int'(d_dep[0]), 1);
    step("x", 1'b1);
    chk("t2_x_depth", int'(d_dep[0]), 0);
    chk("t2_x_result", int'(d_res[0]), 1);
    step(" ", 1'b1);
    chk("t2_hwm", int'(d_hwm[0]), 0);

    $display("[TB] directed: end begin end");
    do_reset();
    send("en"); step("d", 1'b1);
    chk("t3_d_result", int'(d_res[0]), 0);
    chk("t3_d_uf", int'(d_eu[0]), 0);
    step(" ", 1'b1);
    chk("t3_uf", int'(d_eu[0]), 1);
    send("begin end ");
    chk("t3_dead_depth", int'(d_dep[0]), 0);
    chk("t3_dead_result", int'(d_res[0]), 0);
    do_reset();
    chk("t3_reset_result", int'(d_res[0]), 1);

    $display("[TB] directed: EndX BEGIN eNd");
    do_reset();
    send("EndX ");
    chk("t4_endx_uf", int'(d_eu[0]), 0);
    chk("t4_endx_result", int'(d_res[0]), 1);
    send("BEGIN eN"); step("d", 1'b1);
    chk("t4_ci_result", int'(d_res[0]), 1);
    chk("t4_ci_hwm", int'(d_hwm[0]), 1);
    chk("t4_cs_depth", int'(d_dep[1]), 0);
    chk("t4_cs_result", int'(d_res[1]), 1);
    chk("t4_cs_hwm", int'(d_hwm[1]), 0);

    $display("[TB] directed: overflow at MAX_DEPTH=2");
    do_reset();
    send("begin begin begi"); step("n", 1'b1);
    chk("t5_n_depth", int'(d_dep[2]), 2);
    step(" ", 1'b1);
    chk("t5_of", int'(d_eo[2]), 1);
    chk("t5_result", int'(d_res[2]), 0);
    chk("t5_hwm", int'(d_hwm[2]), 2);

    $display("[TB] directed: valid gap and mid-word reset");
    do_reset();
    send("be");
    for (int i = 0; i < 3; i++) begin
      step("n", 1'b0);
      chk("t6_gap_depth", int'(d_dep[0]), 0);
    end
    send("gin");
    chk("t6_depth", int'(d_dep[0]), 1);
    send(" be");
    reset = 1'b1;
    step("g", 1'b1);
    reset = 1'b0;
    chk("t6_rst_depth", int'(d_dep[0]), 0);
    chk("t6_rst_hwm", int'(d_hwm[0]), 0);
    chk("t6_rst_result", int'(d_res[0]), 1);
    send("gin");
    chk("t6_rst_sep_depth", int'(d_dep[0]), 0);

    $display("[TB] random word stream");
    for (int w = 0; w < 1500; w++) begin
      string s;
      s = words[$urandom_range(0, 9)];
      for (int i = 0; i < s.len(); i++) begin
        if ($urandom_range(0, 9) == 0) step(8'($urandom_range(0, 255)), 1'b0);
        step(s[i], 1'b1);
      end
      send(seps[$urandom_range(0, 4)]);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
